// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 5-stage pipeline sequencer.
package pipeline_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } seq_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detect: load in EX feeding an operand of the instruction in ID.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  output logic             lu_c
);

  logic rs_hit;
  logic rt_hit;

  // $0 is hardwired, so a load targeting it never creates a dependency
  always_comb begin
    rs_hit = id_uses_rs && (id_rs == ex_rt);
    rt_hit = id_uses_rt && (id_rt == ex_rt);
    lu_c   = ex_mem_read && (ex_rt != '0) && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: memory wait FSM, stall/flush priority mux and saturating event counters.
module pipeline_sequencer
  import pipeline_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned WAIT_W      = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_MemRead,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_MemRead,
  input  logic             mem_MemWrite,
  input  logic             mem_ack,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             memwb_bubble,
  output logic             mem_req,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  seq_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic [CNT_W-1:0]  flush_count_q, flush_count_d;
  logic              mem_op;
  logic              freeze;
  logic              lu;

  load_use_detect u_lu (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_MemRead),
    .ex_rt       (ex_rt),
    .lu_c        (lu)
  );

  assign mem_op = mem_MemRead | mem_MemWrite;

  // Memory handshake FSM; freeze marks cycles where no pipe register may move
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    freeze     = 1'b0;
    mem_req    = 1'b0;
    case (state_q)
      RUN: begin
        mem_req = mem_op;
        if (mem_op && !mem_ack) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
          freeze     = 1'b1;
        end
      end
      MEM_WAIT: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          freeze = 1'b1;
          if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
            state_d = ERROR;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
      end
      ERROR: begin
        freeze = 1'b1;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
    if (reset) begin
      mem_req = 1'b0;
    end
  end

  // Priority: reset > freeze > branch taken > load-use > jump > advance
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_flush   = 1'b0;
    exmem_write  = 1'b1;
    memwb_bubble = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
    end else if (freeze) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else if (id_jump) begin
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (!pc_write && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
    if (ifid_flush && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign mem_error   = (state_q == ERROR);
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer with hand-computed output patterns.
module tb_pipeline_sequencer;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rs, id_uses_rt, id_jump;
  logic        ex_MemRead, ex_branch_taken;
  logic        mem_MemRead, mem_MemWrite, mem_ack;
  logic        pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic        exmem_write, memwb_bubble, mem_req, mem_error;
  logic [15:0] stall_count, flush_count;

  int total = 0;
  int bad   = 0;

  // {pc_w, ifid_w, ifid_fl, idex_w, idex_fl, exmem_w, memwb_bub, mem_req, mem_err}
  localparam logic [8:0] P_RESET  = 9'b001010100;
  localparam logic [8:0] P_IDLE   = 9'b110101000;
  localparam logic [8:0] P_LU     = 9'b000111000;
  localparam logic [8:0] P_BRANCH = 9'b111111000;
  localparam logic [8:0] P_JUMP   = 9'b111101000;
  localparam logic [8:0] P_FREEZE = 9'b000000110;
  localparam logic [8:0] P_ACK    = 9'b110101010;
  localparam logic [8:0] P_ERROR  = 9'b000000101;

  logic [8:0] outs;
  assign outs = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
                 exmem_write, memwb_bubble, mem_req, mem_error};

  pipeline_sequencer #(.MEM_TIMEOUT(4), .WAIT_W(4), .CNT_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_jump         (id_jump),
    .ex_MemRead      (ex_MemRead),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .mem_MemRead     (mem_MemRead),
    .mem_MemWrite    (mem_MemWrite),
    .mem_ack         (mem_ack),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_write      (idex_write),
    .idex_flush      (idex_flush),
    .exmem_write     (exmem_write),
    .memwb_bubble    (memwb_bubble),
    .mem_req         (mem_req),
    .mem_error       (mem_error),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [8:0] exp);
    #2;
    check_val(tag, 32'(outs), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_jump = 1'b0;
    ex_MemRead = 1'b0; ex_branch_taken = 1'b0;
    mem_MemRead = 1'b0; mem_MemWrite = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    check_outs("reset_outs", P_RESET);
    tick();
    reset = 1'b0;
    check_val("reset_stall", 32'(stall_count), 32'd0);
    check_val("reset_flush", 32'(flush_count), 32'd0);
    check_outs("idle", P_IDLE);
    tick();

    // load-use on rs
    ex_MemRead = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
    check_outs("lu_rs", P_LU);
    tick();
    clear_inputs();
    check_outs("lu_after", P_IDLE);
    check_val("lu_stall_cnt", 32'(stall_count), 32'd1);
    tick();

    // load to $0 never stalls
    ex_MemRead = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    check_outs("lu_zero", P_IDLE);
    tick();
    // rt match only counts when rt is read
    clear_inputs();
    ex_MemRead = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b0;
    check_outs("lu_rt_unused", P_IDLE);
    id_uses_rt = 1'b1;
    check_outs("lu_rt", P_LU);
    tick();
    clear_inputs();
    check_val("lu_rt_stall_cnt", 32'(stall_count), 32'd2);

    // branch taken beats load-use
    ex_MemRead = 1'b1; ex_rt = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b1; ex_branch_taken = 1'b1;
    check_outs("branch_lu", P_BRANCH);
    tick();
    clear_inputs();
    check_val("branch_flush_cnt", 32'(flush_count), 32'd1);
    check_val("branch_stall_cnt", 32'(stall_count), 32'd2);

    // plain jump
    id_jump = 1'b1;
    check_outs("jump", P_JUMP);
    tick();
    clear_inputs();
    check_outs("jump_after", P_IDLE);
    check_val("jump_flush_cnt", 32'(flush_count), 32'd2);

    // JR with load-use: stall then flush
    id_jump = 1'b1; id_uses_rs = 1'b1; id_rs = 5'd9; ex_MemRead = 1'b1; ex_rt = 5'd9;
    check_outs("jr_stall", P_LU);
    tick();
    ex_MemRead = 1'b0; ex_rt = 5'd0;
    check_outs("jr_flush", P_JUMP);
    tick();
    clear_inputs();
    check_val("jr_stall_cnt", 32'(stall_count), 32'd3);
    check_val("jr_flush_cnt", 32'(flush_count), 32'd3);

    // memory wait: 3 freeze cycles, ack on the 4th
    pulse_reset();
    check_val("rst2_stall", 32'(stall_count), 32'd0);
    mem_MemRead = 1'b1;
    check_outs("mw_c0", P_FREEZE);
    tick();
    ex_branch_taken = 1'b1;
    check_outs("mw_c1_branch", P_FREEZE);
    tick();
    ex_branch_taken = 1'b0;
    check_outs("mw_c2", P_FREEZE);
    tick();
    mem_ack = 1'b1;
    check_outs("mw_ack", P_ACK);
    tick();
    clear_inputs();
    check_outs("mw_after", P_IDLE);
    check_val("mw_stall_cnt", 32'(stall_count), 32'd3);
    check_val("mw_flush_cnt", 32'(flush_count), 32'd0);

    // zero-wait store
    mem_MemWrite = 1'b1; mem_ack = 1'b1;
    check_outs("zero_wait", P_ACK);
    tick();
    clear_inputs();
    check_val("zero_wait_stall", 32'(stall_count), 32'd3);

    // timeout: RUN + wait_cnt 1..4 frozen with request, then ERROR
    mem_MemRead = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_outs($sformatf("to_wait%0d", i), P_FREEZE);
      tick();
    end
    check_outs("to_error", P_ERROR);
    tick();
    mem_MemRead = 1'b0; mem_ack = 1'b1;
    check_outs("error_sticky", P_ERROR);
    tick();
    clear_inputs();
    check_val("error_stall_cnt", 32'(stall_count), 32'd10);

    // asynchronous reset during MEM_WAIT
    pulse_reset();
    mem_MemRead = 1'b1;
    tick();
    tick();
    check_val("pre_async_stall", 32'(stall_count), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check_val("async_stall", 32'(stall_count), 32'd0);
    check_outs("async_outs", P_RESET);
    #1;
    reset = 1'b0;
    mem_MemRead = 1'b0;
    check_outs("async_run", P_IDLE);
    tick();
    check_val("async_run_stall", 32'(stall_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
